// File: rtl/copy_err_monitor.sv
// -----------------------------------------------------------------------------
// copy_err_monitor
//
// Error-statistics monitor placed directly after a copy-type approximate adder.
// For each accepted sample it recomputes the exact sum A+B. It then forms the
// signed error exact-APPROX. Over a window of 2^N_LOG2 accepted samples it
// accumulates the following metrics:
//   sum_abs_err : sum of |exact-APPROX|
//   max_err     : largest |exact-APPROX|
//   err_count   : samples whose error is nonzero
//   neg_count   : samples where APPROX > exact
// When the window is complete, the results are presented through a
// valid/ready handshake.
//
// Optional feature (macro COPY_ERR_MON_SQ_EN):
//   Adds output sum_sq_err, the sum of |exact-APPROX|^2 over the window.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         begin a new window (honoured in IDLE only)
//   in_valid      sample valid
//   in_ready      sample accepted (high only while collecting)
//   A, B          adder operands
//   APPROX        approximate adder output for this A, B
//   res_valid     result valid, held until res_ready
//   res_ready     result consumed
//   sum_abs_err, max_err, err_count, neg_count [, sum_sq_err]
//                 window metrics; they keep their values in IDLE and are
//                 cleared on the next accepted start
// -----------------------------------------------------------------------------
module copy_err_monitor #(
  parameter int BIT_WIDTH = 8,
  parameter int N_LOG2    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIT_WIDTH-1:0]          A,
  input  logic [BIT_WIDTH-1:0]          B,
  input  logic [BIT_WIDTH:0]            APPROX,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [BIT_WIDTH+N_LOG2:0]     sum_abs_err,
  output logic [BIT_WIDTH:0]            max_err,
  output logic [N_LOG2:0]               err_count,
  output logic [N_LOG2:0]               neg_count
`ifdef COPY_ERR_MON_SQ_EN
  ,
  output logic [2*(BIT_WIDTH+1)+N_LOG2-1:0] sum_sq_err
`endif
);

  localparam int EW = BIT_WIDTH + 1;  // error magnitude width
  localparam int DW = BIT_WIDTH + 2;  // signed difference width
  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t              state;
  logic [N_LOG2-1:0]   smp_cnt;
  logic                drain_cnt;

  // |d| for a signed difference. The most negative value, -(2^EW - 1),
  // still has a magnitude that fits in EW bits.
  function automatic logic [EW-1:0] abs_err(input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    m = (d < 0) ? -d : d;
    return m[EW-1:0];
  endfunction

  // ---- stage 0: exact sum and signed error (combinational) ----
  logic                  accept;
  logic                  clear;
  logic [EW-1:0]         exact_p0;
  logic signed [DW-1:0]  diff_p0;

  assign accept   = in_valid && in_ready;
  assign clear    = (state == S_IDLE) && start;
  assign exact_p0 = {1'b0, A} + {1'b0, B};
  assign diff_p0  = $signed({1'b0, exact_p0}) - $signed({1'b0, APPROX});

  // Control FSM. in_ready and res_valid are registered. They are updated
  // together with each state change, so each one always matches the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            smp_cnt  <= '0;
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_cnt == CNT_LAST) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        // The last sample sits in stage 1 on the first drain cycle. It is
        // accumulated on the second drain cycle, so results are final when
        // REPORT is entered.
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state     <= S_REPORT;
            res_valid <= 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage 1: registered error magnitude and sign ----
  logic            vld_p1;
  logic [EW-1:0]   abs_p1;
  logic            neg_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      abs_p1 <= '0;
      neg_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        abs_p1 <= abs_err(diff_p0);
        neg_p1 <= (diff_p0 < 0);
      end
    end
  end

  // ---- stage 2: accumulate ----
`ifdef COPY_ERR_MON_SQ_EN
  logic [2*EW-1:0] sq_p1;
  assign sq_p1 = abs_p1 * abs_p1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_abs_err <= '0;
      max_err     <= '0;
      err_count   <= '0;
      neg_count   <= '0;
`ifdef COPY_ERR_MON_SQ_EN
      sum_sq_err  <= '0;
`endif
    end else if (clear) begin
      sum_abs_err <= '0;
      max_err     <= '0;
      err_count   <= '0;
      neg_count   <= '0;
`ifdef COPY_ERR_MON_SQ_EN
      sum_sq_err  <= '0;
`endif
    end else if (vld_p1) begin
      sum_abs_err <= sum_abs_err + {{N_LOG2{1'b0}}, abs_p1};
      if (abs_p1 > max_err) begin
        max_err <= abs_p1;
      end
      err_count   <= err_count + {{N_LOG2{1'b0}}, (abs_p1 != '0)};
      neg_count   <= neg_count + {{N_LOG2{1'b0}}, neg_p1};
`ifdef COPY_ERR_MON_SQ_EN
      sum_sq_err  <= sum_sq_err + {{N_LOG2{1'b0}}, sq_p1};
`endif
    end
  end

endmodule
